// File: rtl/mmio_bridge_ctrl.sv
// MCS IO-bus to MMIO slot bridge: registers one bus access, strobes the decoded slot for one
// cycle, then returns io_ready with the selected slot's read data. Fixed 2-cycle latency.
module mmio_bridge_ctrl #(
    parameter int          NUM_SLOTS   = 32,
    parameter logic [7:0]  BRIDGE_BASE = 8'hC0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          io_addr_strobe,
    input  logic                          io_read_strobe,
    input  logic                          io_write_strobe,
    input  logic [31:0]                   io_address,
    input  logic [3:0]                    io_byte_enable,
    input  logic [31:0]                   io_write_data,
    output logic [31:0]                   io_read_data,
    output logic                          io_ready,
    output logic [NUM_SLOTS-1:0]          slot_cs_array,
    output logic                          slot_read,
    output logic                          slot_write,
    output logic [4:0]                    slot_reg_addr,
    output logic [31:0]                   slot_wr_data,
    input  logic [NUM_SLOTS-1:0][31:0]    slot_rd_data_arr
);
    localparam int IDX_W = $clog2(NUM_SLOTS);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t               state_reg;
    logic                 write_reg;
    logic                 in_range_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic [NUM_SLOTS-1:0] cs_decode;
    logic                 req;
    logic                 hit;
    logic [IDX_W-1:0]     idx;

    // Byte enables and the don't-care address bits are intentionally not decoded.
    logic unused_bits;
    assign unused_bits = ^{io_byte_enable, io_address[23:12], io_address[1:0]};

    assign req = io_addr_strobe && (io_read_strobe || io_write_strobe);
    assign hit = (io_address[31:24] == BRIDGE_BASE);
    assign idx = io_address[7 +: IDX_W];

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_cs
            assign cs_decode[gi] = hit && (idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            write_reg     <= 1'b0;
            in_range_reg  <= 1'b0;
            idx_reg       <= '0;
            io_ready      <= 1'b0;
            io_read_data  <= 32'd0;
            slot_cs_array <= '0;
            slot_read     <= 1'b0;
            slot_write    <= 1'b0;
            slot_reg_addr <= 5'd0;
            slot_wr_data  <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    io_ready <= 1'b0;
                    if (req) begin
                        // Write wins when both strobes are high.
                        slot_cs_array <= cs_decode;
                        slot_write    <= io_write_strobe;
                        slot_read     <= !io_write_strobe;
                        slot_reg_addr <= io_address[6:2];
                        slot_wr_data  <= io_write_data;
                        write_reg     <= io_write_strobe;
                        in_range_reg  <= hit;
                        idx_reg       <= idx;
                        state_reg     <= ACCESS;
                    end
                end
                ACCESS: begin
                    slot_cs_array <= '0;
                    slot_read     <= 1'b0;
                    slot_write    <= 1'b0;
                    io_ready      <= 1'b1;
                    io_read_data  <= (!write_reg && in_range_reg) ? slot_rd_data_arr[idx_reg] : 32'd0;
                    state_reg     <= ACK;
                end
                ACK: begin
                    io_ready  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_bridge_ctrl.sv
// Bench for mmio_bridge_ctrl: 32 register-file slot models, a transaction-level reference model
// and directed plus randomized bus traffic.
module tb_mmio_bridge_ctrl;
    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              io_addr_strobe = 1'b0;
    logic              io_read_strobe = 1'b0;
    logic              io_write_strobe = 1'b0;
    logic [31:0]       io_address = 32'd0;
    logic [3:0]        io_byte_enable = 4'hF;
    logic [31:0]       io_write_data = 32'd0;
    logic [31:0]       io_read_data;
    logic              io_ready;
    logic [31:0]       slot_cs_array;
    logic              slot_read;
    logic              slot_write;
    logic [4:0]        slot_reg_addr;
    logic [31:0]       slot_wr_data;
    logic [31:0][31:0] slot_rd_data_arr;

    mmio_bridge_ctrl #(.NUM_SLOTS(32), .BRIDGE_BASE(8'hC0)) dut (
        .clk(clk), .reset(reset),
        .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_address(io_address),
        .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
        .io_read_data(io_read_data), .io_ready(io_ready),
        .slot_cs_array(slot_cs_array), .slot_read(slot_read), .slot_write(slot_write),
        .slot_reg_addr(slot_reg_addr), .slot_wr_data(slot_wr_data),
        .slot_rd_data_arr(slot_rd_data_arr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(int s, int r);
        return 32'h1000_0000 + 32'(s * 256 + r);
    endfunction

    // Slot models: 32 registers each, combinational read, write on cs & slot_write.
    logic [31:0] mem [32][32];
    logic        mem_ready = 1'b0;
    always @(posedge clk) begin
        if (reset && !mem_ready) begin
            for (int s = 0; s < 32; s++)
                for (int r = 0; r < 32; r++)
                    mem[s][r] <= init_val(s, r);
            mem_ready <= 1'b1;
        end else begin
            for (int s = 0; s < 32; s++)
                if (slot_cs_array[s] && slot_write) mem[s][slot_reg_addr] <= slot_wr_data;
        end
    end
    always_comb begin
        for (int s = 0; s < 32; s++) slot_rd_data_arr[s] = mem[s][slot_reg_addr];
    end

    // Reference model: one accepted access at a time, described by cycle of acceptance.
    logic [31:0] ref_mem [32][32];
    int          cyc = 0;
    int          acc_cycle = -100;
    bit          acc_w, acc_in;
    int          acc_idx, acc_reg;
    logic [31:0] acc_data, acc_rdval, exp_rd;
    int          vectors = 0, miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic compare_cycle();
        logic [31:0] e_cs;
        logic        e_rd, e_wr, e_rdy;
        e_cs = 32'd0; e_rd = 1'b0; e_wr = 1'b0; e_rdy = 1'b0;
        if (reset) begin
            exp_rd = 32'd0;
            return;
        end
        if (acc_cycle == cyc - 1) begin
            e_cs = acc_in ? (32'd1 << acc_idx) : 32'd0;
            e_rd = !acc_w;
            e_wr = acc_w;
            acc_rdval = acc_in ? ref_mem[acc_idx][acc_reg] : 32'd0;
            if (acc_w && acc_in) ref_mem[acc_idx][acc_reg] = acc_data;
            chk("reg_addr", 32'(slot_reg_addr), 32'(acc_reg));
            chk("wr_data", slot_wr_data, acc_data);
        end
        if (acc_cycle == cyc - 2) begin
            e_rdy = 1'b1;
            exp_rd = acc_w ? 32'd0 : acc_rdval;
        end
        chk("cs", slot_cs_array, e_cs);
        chk("slot_read", 32'(slot_read), 32'(e_rd));
        chk("slot_write", 32'(slot_write), 32'(e_wr));
        chk("io_ready", 32'(io_ready), 32'(e_rdy));
        chk("io_read_data", io_read_data, exp_rd);
    endtask

    task automatic do_cycle(input bit stb, input bit rd, input bit wr,
                            input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk);
        cyc++;
        #1;
        io_addr_strobe  = stb;
        io_read_strobe  = rd;
        io_write_strobe = wr;
        io_address      = addr;
        io_write_data   = data;
        io_byte_enable  = 4'($urandom);
        if (stb && (rd || wr) && !reset && (cyc - acc_cycle >= 3)) begin
            acc_cycle = cyc;
            acc_w     = wr;
            acc_in    = (addr[31:24] == 8'hC0);
            acc_idx   = int'(addr[11:7]);
            acc_reg   = int'(addr[6:2]);
            acc_data  = data;
        end
        @(negedge clk);
        compare_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_cs"}, slot_cs_array, 32'd0);
        chk({tag, "_rw"}, 32'({slot_read, slot_write}), 32'd0);
        chk({tag, "_ready"}, 32'(io_ready), 32'd0);
        chk({tag, "_rdata"}, io_read_data, 32'd0);
        chk({tag, "_regaddr"}, 32'(slot_reg_addr), 32'd0);
        chk({tag, "_wrdata"}, slot_wr_data, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        for (int s = 0; s < 32; s++)
            for (int r = 0; r < 32; r++)
                ref_mem[s][r] = init_val(s, r);
        exp_rd = 32'd0;

        idle(3);
        check_zero_outputs("por");
        reset = 1'b0;
        idle(2);

        // Write slot 2 reg 1.
        do_cycle(1, 0, 1, 32'hC000_0104, 32'h0000_A5A5);
        idle(2);
        chk("gpo_slot2", mem[2][1], 32'h0000_A5A5);

        // Load slot 5 reg 2 then read it back.
        do_cycle(1, 0, 1, 32'hC000_0288, 32'h1234_5678);
        idle(2);
        do_cycle(1, 1, 0, 32'hC000_0288, 32'h0);
        idle(2);
        chk("read_slot5", io_read_data, 32'h1234_5678);

        // Out-of-range read returns 0.
        do_cycle(1, 1, 0, 32'h8000_0104, 32'h0);
        idle(2);
        chk("oor_ready", 32'(io_ready), 32'd1);
        chk("oor_rdata", io_read_data, 32'd0);

        // Collision: both strobes, then a stray strobe one cycle later.
        do_cycle(1, 1, 1, 32'hC000_0308, 32'h0000_C0DE);
        do_cycle(1, 0, 1, 32'hC000_0388, 32'h0000_BAD0);
        idle(2);
        chk("collide_wr", mem[6][2], 32'h0000_C0DE);
        chk("stray_ign", mem[7][2], init_val(7, 2));

        // Back-to-back writes to slots 0..3.
        for (int s = 0; s < 4; s++) begin
            a = 32'hC000_0000 | (32'(s) << 7) | (32'(s) << 2);
            do_cycle(1, 0, 1, a, 32'h0000_B000 + 32'(s));
            idle(2);
        end
        for (int s = 0; s < 4; s++) chk("b2b_data", mem[s][s], 32'h0000_B000 + 32'(s));

        // Reset during ACCESS of a write to slot 3 reg 1: write aborted, no io_ready.
        do_cycle(1, 0, 1, 32'hC000_0184, 32'h0000_DEAD);
        @(posedge clk);
        cyc++;
        #1;
        io_addr_strobe = 1'b0; io_read_strobe = 1'b0; io_write_strobe = 1'b0;
        chk("rst_pre_access", 32'(slot_write), 32'd1);
        reset = 1'b1;
        #1;
        check_zero_outputs("rst_mid");
        acc_cycle = -100;
        idle(2);
        reset = 1'b0;
        idle(3);
        do_cycle(1, 1, 0, 32'hC000_0184, 32'h0);
        idle(2);
        chk("rst_abort", io_read_data, init_val(3, 1));

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[31:24] = 8'hC0;
            a[11:7] = 5'($urandom_range(0, 7));
            a[6:2]  = 5'($urandom_range(0, 3));
            do_cycle(1'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), a, $urandom);
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
